// File: rtl/dm_access_arbiter_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Channel identifiers, also used as the encoding of the last-owner flag.
    localparam logic CH_SORT = 1'b0;
    localparam logic CH_SDU  = 1'b1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Requester, memory and statistics signals of the data-memory arbiter.
interface dm_access_arbiter_if #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic          req0, req1;
    logic          lock0, lock1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_spo;
    logic          busy;
    logic          cnt_clr;
    logic [CNT_W-1:0] gcnt0, gcnt1;

    // Arbiter side.
    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_spo, cnt_clr,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_a, mem_d, mem_we, busy, gcnt0, gcnt1
    );

    // Requester / memory / host side.
    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_spo, cnt_clr,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_a, mem_d, mem_we, busy, gcnt0, gcnt1
    );
endinterface

// File: rtl/dm_access_arbiter_satcnt.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module dm_arb_satcnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/dm_access_arbiter.sv
// Two-channel req/gnt arbiter for a shared distributed RAM (async read, sync write):
// ch0 = sort engine, ch1 = SDU debug port. Supports locking for RMW swaps, a bounded
// hold time under contention, registered read data and saturating grant counters.
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    dm_access_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW:0] MAX_HOLD_W = (HW + 1)'(MAX_HOLD);

    arb_state_e    state_q;
    logic          last_q;
    logic [HW-1:0] hold_q;

    logic          gnt0, gnt1;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic          own_req, own_lock, oth_req, own_gnt;
    logic [HW:0]   hold_sum;
    logic [HW-1:0] hold_sat;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    // Grant and memory mux follow the current owner; idle drives a quiet bus.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        mem_a    = '0;
        mem_d    = '0;
        mem_we   = 1'b0;
        own_req  = 1'b0;
        own_lock = 1'b0;
        oth_req  = 1'b0;
        unique case (state_q)
            ST_OWN0: begin
                gnt0     = bus.req0;
                mem_a    = bus.addr0;
                mem_d    = bus.wdata0;
                mem_we   = bus.req0 & bus.we0;
                own_req  = bus.req0;
                own_lock = bus.lock0;
                oth_req  = bus.req1;
            end
            ST_OWN1: begin
                gnt1     = bus.req1;
                mem_a    = bus.addr1;
                mem_d    = bus.wdata1;
                mem_we   = bus.req1 & bus.we1;
                own_req  = bus.req1;
                own_lock = bus.lock1;
                oth_req  = bus.req0;
            end
            default: ;
        endcase
    end

    // Hold count including this cycle's grant; saturates so a long lock cannot wrap it.
    always_comb begin
        own_gnt  = gnt0 | gnt1;
        hold_sum = {1'b0, hold_q} + {{HW{1'b0}}, own_gnt};
        hold_sat = (hold_sum >= MAX_HOLD_W) ? MAX_HOLD_W[HW-1:0] : hold_sum[HW-1:0];
    end

    // Arbiter FSM: ownership, last-owner tie breaker and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= CH_SDU;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.req0 && bus.req1)
                        state_q <= (last_q == CH_SDU) ? ST_OWN0 : ST_OWN1;
                    else if (bus.req0)
                        state_q <= ST_OWN0;
                    else if (bus.req1)
                        state_q <= ST_OWN1;
                end
                ST_OWN0, ST_OWN1: begin
                    if (own_lock) begin
                        hold_q <= hold_sat;
                    end else if (oth_req && (!own_req || (hold_sum >= MAX_HOLD_W))) begin
                        state_q <= (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
                        hold_q  <= '0;
                        last_q  <= (state_q == ST_OWN0) ? CH_SORT : CH_SDU;
                    end else if (!own_req) begin
                        state_q <= ST_IDLE;
                        hold_q  <= '0;
                        last_q  <= (state_q == ST_OWN0) ? CH_SORT : CH_SDU;
                    end else begin
                        hold_q <= hold_sat;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Capture async RAM data on granted reads; rvalid pulses for one cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 & ~bus.we0;
            rvalid1_q <= gnt1 & ~bus.we1;
            if (gnt0 && !bus.we0) rdata0_q <= bus.mem_spo;
            if (gnt1 && !bus.we1) rdata1_q <= bus.mem_spo;
        end
    end

    dm_arb_satcnt #(.CNT_W(CNT_W)) u_gcnt0 (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.cnt_clr),
        .inc_i (gnt0),
        .cnt_o (bus.gcnt0)
    );

    dm_arb_satcnt #(.CNT_W(CNT_W)) u_gcnt1 (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.cnt_clr),
        .inc_i (gnt1),
        .cnt_o (bus.gcnt1)
    );

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.mem_a   = mem_a;
    assign bus.mem_d   = mem_d;
    assign bus.mem_we  = mem_we;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.busy    = (state_q != ST_IDLE);
endmodule
